tx_min_frame_pad: RTL

//  AXI4-Stream stage in the clk domain, directly upstream of the 10G TX AXI-to-MAC queue.

---
 rtl/tx_min_frame_pad.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tx_min_frame_pad.sv
// rtl/tx_min_frame_pad.sv - AXI-Stream min-frame zero padder with registered output slice and statistics.
module tx_min_frame_pad #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MIN_BYTES      = 60
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [AXI_DATA_WIDTH-1:0]   s_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_tstrb,
    input  logic                        s_tvalid,
    input  logic                        s_tlast,
    output logic                        s_tready,
    output logic [AXI_DATA_WIDTH-1:0]   m_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_tstrb,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [31:0]                 pkt_count,
    output logic [31:0]                 pad_count,
    output logic [31:0]                 bad_strb_count
);
    localparam int                      KW        = AXI_DATA_WIDTH / 8;
    localparam int                      LAST_W    = (MIN_BYTES - 1) / 8;
    localparam int                      LAST_POP  = MIN_BYTES - 8 * LAST_W;
    localparam logic [KW-1:0]           LAST_STRB = KW'((1 << LAST_POP) - 1);
    localparam logic [2:0]              LAST_W3   = 3'(LAST_W);

    typedef enum logic {PASS, PAD} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                widx_q, widx_d, widx_hs;
    logic [AXI_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d, s_data_masked;
    logic [KW-1:0]             m_tstrb_q, m_tstrb_d;
    logic                      m_tvalid_q, m_tvalid_d;
    logic                      m_tlast_q, m_tlast_d;
    logic                      m_padded_q, m_padded_d;
    logic [31:0]               pkt_count_q, pkt_count_d;
    logic [31:0]               pad_count_q, pad_count_d;
    logic [31:0]               bad_strb_count_q, bad_strb_count_d;
    logic                      slot_free, out_hs, accept, strb_contig;

    always_comb begin
        slot_free   = ~m_tvalid_q | m_tready;
        out_hs      = m_tvalid_q & m_tready;
        s_tready    = reset_n & (state_q == PASS) & slot_free;
        accept      = s_tvalid & s_tready;
        strb_contig = (s_tstrb != '0) && ((s_tstrb & (s_tstrb + KW'(1))) == '0);
        for (int i = 0; i < KW; i++) begin
            s_data_masked[8*i +: 8] = s_tstrb[i] ? s_tdata[8*i +: 8] : 8'h00;
        end

        // Index of the word loaded this cycle: the slot's beat has left if a handshake happens.
        widx_hs = widx_q;
        if (out_hs) begin
            if (m_tlast_q) begin
                widx_hs = 3'd0;
            end else if (widx_q != LAST_W3) begin
                widx_hs = widx_q + 3'd1;
            end
        end

        state_d          = state_q;
        widx_d           = widx_hs;
        m_tdata_d        = m_tdata_q;
        m_tstrb_d        = m_tstrb_q;
        m_tlast_d        = m_tlast_q;
        m_padded_d       = m_padded_q;
        m_tvalid_d       = slot_free ? 1'b0 : m_tvalid_q;
        pkt_count_d      = pkt_count_q;
        pad_count_d      = pad_count_q;
        bad_strb_count_d = bad_strb_count_q;

        if (out_hs && m_tlast_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
            if (m_padded_q) begin
                pad_count_d = pad_count_q + 32'd1;
            end
        end
        if (accept && !strb_contig && !(s_tlast && s_tstrb == '0)) begin
            bad_strb_count_d = bad_strb_count_q + 32'd1;
        end

        case (state_q)
            PASS: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_data_masked;
                    m_tstrb_d  = s_tstrb;
                    m_tlast_d  = 1'b0;
                    m_padded_d = 1'b0;
                    if (s_tlast) begin
                        if (widx_hs < LAST_W3) begin
                            m_tstrb_d = '1;
                            state_d   = PAD;
                        end else if (widx_hs == LAST_W3 && $countones(s_tstrb) < LAST_POP) begin
                            m_tstrb_d  = LAST_STRB;
                            m_tlast_d  = 1'b1;
                            m_padded_d = 1'b1;
                        end else begin
                            m_tlast_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = '0;
                    if (widx_hs < LAST_W3) begin
                        m_tstrb_d = '1;
                        m_tlast_d = 1'b0;
                    end else begin
                        m_tstrb_d  = LAST_STRB;
                        m_tlast_d  = 1'b1;
                        m_padded_d = 1'b1;
                        state_d    = PASS;
                    end
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= PASS;
            widx_q           <= 3'd0;
            m_tdata_q        <= '0;
            m_tstrb_q        <= '0;
            m_tvalid_q       <= 1'b0;
            m_tlast_q        <= 1'b0;
            m_padded_q       <= 1'b0;
            pkt_count_q      <= 32'd0;
            pad_count_q      <= 32'd0;
            bad_strb_count_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            widx_q           <= widx_d;
            m_tdata_q        <= m_tdata_d;
            m_tstrb_q        <= m_tstrb_d;
            m_tvalid_q       <= m_tvalid_d;
            m_tlast_q        <= m_tlast_d;
            m_padded_q       <= m_padded_d;
            pkt_count_q      <= pkt_count_d;
            pad_count_q      <= pad_count_d;
            bad_strb_count_q <= bad_strb_count_d;
        end
    end

    assign m_tdata        = m_tdata_q;
    assign m_tstrb        = m_tstrb_q;
    assign m_tvalid       = m_tvalid_q;
    assign m_tlast        = m_tlast_q;
    assign pkt_count      = pkt_count_q;
    assign pad_count      = pad_count_q;
    assign bad_strb_count = bad_strb_count_q;
endmodule
